duty_ramp_ctrl: RTL and testbench
=================================

# duty_ramp_ctrl

Upstream duty-cycle controller for the 8-channel PWM generator. It accepts per-channel target duty commands over a valid/ready handshake, then moves each channel's current duty toward its target, either immediately or by a ±1 ramp (fade). It updates its parallel duty output only at PWM period boundaries, so the generator never sees a mid-period change. A period-start pulse from the PWM counter wrap drives the update; the duty bus feeds the generator's per-channel comparators.

## Interface
- NUM_CH, 8: channel count.
- DUTY_W, 7: duty width in bits.
- DUTY_MAX, 100: maximum duty, equal to PWM counter period.
- STEP_DIV, 4: PWM periods per ramp step (≥1).

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- period_start  in  1  one-cycle pulse when the PWM counter wraps to 0.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_ch  in  3  target channel.
- cmd_duty  in  DUTY_W  target duty; values above DUTY_MAX are clamped to DUTY_MAX.
- cmd_ramp  in  1  1 = ramp toward target; 0 = jump at next boundary.
- duty_flat  out  NUM_CH*DUTY_W  registered duty; channel k occupies [k*DUTY_W +: DUTY_W].
- upd  out  1  one-cycle pulse in the cycle duty_flat is reloaded.
- busy  out  1  any channel has current ≠ target or a pending jump.

## Operation
- Per-channel state: tgt[k], cur[k], jump[k]. Also a step_cnt prescaler, 0..STEP_DIV-1.
- Command accept: cmd_valid & cmd_ready.
  - On accept: tgt[cmd_ch] <= clamp(cmd_duty); jump[cmd_ch] <= ~cmd_ramp.
  - Repeated commands to one channel before a sweep: last wins, including the jump flag.
- FSM states: IDLE, SWEEP, LOAD.
  - cmd_ready = (state == IDLE), decoded combinationally from state.
- IDLE + period_start: step_tick <= (step_cnt == STEP_DIV-1); step_cnt increments with wrap; go to SWEEP with ch_idx = 0.
- SWEEP: one channel per cycle, ch_idx 0..NUM_CH-1.
  - if jump[ch]: cur <= tgt, jump <= 0.
  - else if step_tick and cur < tgt: cur + 1.
  - else if step_tick and cur > tgt: cur − 1.
  - After channel NUM_CH-1, go to LOAD.
- LOAD: duty_flat <= all cur[] simultaneously; upd = 1; go to IDLE.
- period_start in SWEEP or LOAD is ignored and does not advance step_cnt. Integration must guarantee PWM period ≥ NUM_CH+2 cycles.
- A command and period_start arriving in the same IDLE cycle are both taken. The sweep uses the new target and jump flag.
- busy = OR over k of ((cur[k] ≠ tgt[k]) | jump[k]), decoded combinationally.
- Arithmetic: unsigned DUTY_W bits. cur never leaves the range 0..DUTY_MAX, so no wrap can occur.

## Timing
- Reset (async, immediate):
  - state = IDLE; all tgt, cur, jump, step_cnt and duty_flat = 0.
  - upd = 0, busy = 0, cmd_ready = 1.
- Reset mid-sweep aborts the sweep. duty_flat goes to 0 immediately, and no upd pulse is produced.
- Latency:
  - period_start is sampled at edge E0.
  - SWEEP occupies edges E1..E8.
  - LOAD is the cycle after E9, with duty_flat updated and upd high for that one cycle.
- cmd_ready is low for 9 cycles per boundary (SWEEP ×8, LOAD ×1).
- A command held valid during that window is accepted in the first IDLE cycle.
- duty_flat changes only on the LOAD edge and is stable otherwise.
- Ramp rate: 1 LSB per STEP_DIV periods. A full 0→100 fade at the defaults takes 400 periods.

## Test plan
- Reset:
  - Stimulus: assert reset mid-run.
  - Required: duty_flat = 0, upd = 0, busy = 0, cmd_ready = 1 while reset is asserted and after release.
- Jump:
  - Stimulus: cmd ch3 duty 40, cmd_ramp = 0; period_start at T.
  - Required: ch3 field = 40 with upd = 1 in the LOAD cycle (9 cycles after T); other fields stay 0; busy = 0 after the sweep.
- Ramp up:
  - Stimulus: STEP_DIV = 4; cmd ch0 duty 5, cmd_ramp = 1; periodic period_start every 100 cycles.
  - Required: ch0 increments by 1 on the 4th, 8th, … boundary and reaches 5 on the 20th; busy falls during that sweep.
- Clamp and ramp down:
  - Stimulus: cmd ch7 duty 127, jump; then cmd ch7 duty 98, ramp.
  - Required: ch7 = 100 at the first boundary; then 99 and 98 on the next two step ticks.
- Handshake and collision:
  - Stimulus: cmd_valid held high (ch1 = 20, jump) from E1 to E9.
  - Required: cmd_ready = 0 for 9 cycles and the command is accepted in the first IDLE cycle. A command in the same cycle as period_start appears in that same LOAD.
- Reset mid-sweep:
  - Stimulus: with ch2 = 60 loaded, assert reset during SWEEP.
  - Required: all outputs zero, no upd pulse; after release, the next period_start yields all-zero duty.

Source files
------------

// File: rtl/duty_ramp_ctrl.sv
// duty_ramp_ctrl: per-channel duty target/current tracker for an 8-channel PWM.
// Targets arrive over valid/ready; at each PWM period boundary one sweep walks
// every channel (jump to target or step by one LSB on a ramp tick), then the
// whole duty bus is reloaded at once so the PWM never sees a mid-period change.
module duty_ramp_ctrl #(
  parameter int NUM_CH   = 8,
  parameter int DUTY_W   = 7,
  parameter int DUTY_MAX = 100,
  parameter int STEP_DIV = 4,
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     period_start,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [CH_W-1:0]          cmd_ch,
  input  logic [DUTY_W-1:0]        cmd_duty,
  input  logic                     cmd_ramp,
  output logic [NUM_CH*DUTY_W-1:0] duty_flat,
  output logic                     upd,
  output logic                     busy
);

  localparam int                SC_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DUTY_W-1:0] DMAX    = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] DUTY_ONE = DUTY_W'(1);
  localparam logic [SC_W-1:0]   SC_LAST = SC_W'(STEP_DIV - 1);
  localparam logic [SC_W-1:0]   SC_ONE  = SC_W'(1);
  localparam logic [CH_W-1:0]   CH_LAST = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0]   CH_ONE  = CH_W'(1);

  typedef enum logic [1:0] {IDLE, SWEEP, LOAD} state_t;

  state_t              state_q;
  logic [DUTY_W-1:0]   tgt_q  [NUM_CH];
  logic [DUTY_W-1:0]   cur_q  [NUM_CH];
  logic [DUTY_W-1:0]   duty_q [NUM_CH];
  logic [NUM_CH-1:0]   jump_q;
  logic [SC_W-1:0]     step_cnt_q;
  logic                step_tick_q;
  logic [CH_W-1:0]     ch_idx_q;
  logic                upd_q;

  logic                cmd_acc;
  logic [DUTY_W-1:0]   cmd_duty_clamped;
  logic [DUTY_W-1:0]   sel_cur;
  logic [DUTY_W-1:0]   sel_tgt;
  logic [DUTY_W-1:0]   cur_d;
  logic [NUM_CH-1:0]   busy_vec;

  // Commands are only taken between sweeps, so tgt/jump never race the sweep.
  assign cmd_ready        = (state_q == IDLE);
  assign cmd_acc          = cmd_valid & cmd_ready;
  assign cmd_duty_clamped = (cmd_duty > DMAX) ? DMAX : cmd_duty;
  assign sel_cur          = cur_q[ch_idx_q];
  assign sel_tgt          = tgt_q[ch_idx_q];

  // New current value for the channel being swept: jump wins over ramp step.
  always_comb begin
    cur_d = sel_cur;
    if (jump_q[ch_idx_q]) begin
      cur_d = sel_tgt;
    end else if (step_tick_q && (sel_cur < sel_tgt)) begin
      cur_d = sel_cur + DUTY_ONE;
    end else if (step_tick_q && (sel_cur > sel_tgt)) begin
      cur_d = sel_cur - DUTY_ONE;
    end
  end

  // Control FSM plus all channel state; outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      step_cnt_q  <= '0;
      step_tick_q <= 1'b0;
      ch_idx_q    <= '0;
      jump_q      <= '0;
      upd_q       <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        tgt_q[k]  <= '0;
        cur_q[k]  <= '0;
        duty_q[k] <= '0;
      end
    end else begin
      upd_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_acc) begin
            tgt_q[cmd_ch]  <= cmd_duty_clamped;
            jump_q[cmd_ch] <= ~cmd_ramp;
          end
          if (period_start) begin
            // Prescaler only advances on boundaries that actually start a sweep.
            step_tick_q <= (step_cnt_q == SC_LAST);
            if (step_cnt_q == SC_LAST) begin
              step_cnt_q <= '0;
            end else begin
              step_cnt_q <= step_cnt_q + SC_ONE;
            end
            ch_idx_q <= '0;
            state_q  <= SWEEP;
          end
        end
        SWEEP: begin
          cur_q[ch_idx_q]  <= cur_d;
          jump_q[ch_idx_q] <= 1'b0;
          if (ch_idx_q == CH_LAST) begin
            state_q <= LOAD;
          end else begin
            ch_idx_q <= ch_idx_q + CH_ONE;
          end
        end
        LOAD: begin
          for (int k = 0; k < NUM_CH; k++) begin
            duty_q[k] <= cur_q[k];
          end
          upd_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pack the output bus and per-channel pending flags.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign duty_flat[gi*DUTY_W +: DUTY_W] = duty_q[gi];
      assign busy_vec[gi] = (cur_q[gi] != tgt_q[gi]) | jump_q[gi];
    end
  endgenerate

  assign busy = |busy_vec;
  assign upd  = upd_q;

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// Bench for duty_ramp_ctrl: directed vector table, hand-written ramp and
// reset-during-sweep sequences, then random traffic against a boundary-level
// reference model.
module tb_duty_ramp_ctrl;

  localparam int NUM_CH   = 8;
  localparam int DUTY_W   = 7;
  localparam int DUTY_MAX = 100;
  localparam int STEP_DIV = 4;
  localparam int SWEEP_LEN = NUM_CH + 1;  // cycles from boundary to reload

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     period_start = 1'b0;
  logic                     cmd_valid = 1'b0;
  logic                     cmd_ready;
  logic [2:0]               cmd_ch = '0;
  logic [DUTY_W-1:0]        cmd_duty = '0;
  logic                     cmd_ramp = 1'b0;
  logic [NUM_CH*DUTY_W-1:0] duty_flat;
  logic                     upd;
  logic                     busy;

  int checks = 0;
  int failures = 0;

  duty_ramp_ctrl #(
    .NUM_CH(NUM_CH), .DUTY_W(DUTY_W), .DUTY_MAX(DUTY_MAX), .STEP_DIV(STEP_DIV)
  ) dut (
    .clk(clk), .reset(reset), .period_start(period_start),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
    .cmd_duty(cmd_duty), .cmd_ramp(cmd_ramp), .duty_flat(duty_flat),
    .upd(upd), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (whole-boundary granularity) ----------
  int m_tgt  [NUM_CH];
  int m_cur  [NUM_CH];
  int m_duty [NUM_CH];
  bit m_jump [NUM_CH];
  int m_win;       // cycles until the block is idle again
  int m_periods;   // boundaries accepted since reset
  bit m_upd;

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_tgt[k] = 0; m_cur[k] = 0; m_duty[k] = 0; m_jump[k] = 0;
    end
    m_win = 0; m_periods = 0; m_upd = 0;
  endtask

  task automatic model_edge(input bit ps, input bit v, input int ch, input int d, input bit rp);
    bit tick;
    m_upd = 0;
    if (m_win == 0) begin
      if (v) begin
        m_tgt[ch]  = (d > DUTY_MAX) ? DUTY_MAX : d;
        m_jump[ch] = !rp;
        $display("cmd  t=%0t ch=%0d duty=%0d ramp=%0b", $time, ch, d, rp);
      end
      if (ps) begin
        m_periods++;
        tick = ((m_periods % STEP_DIV) == 0);
        for (int k = 0; k < NUM_CH; k++) begin
          if (m_jump[k]) begin
            m_cur[k] = m_tgt[k];
            m_jump[k] = 0;
          end else if (tick && m_cur[k] < m_tgt[k]) begin
            m_cur[k]++;
          end else if (tick && m_cur[k] > m_tgt[k]) begin
            m_cur[k]--;
          end
        end
        m_win = SWEEP_LEN;
      end
    end else begin
      m_win--;
      if (m_win == 0) begin
        for (int k = 0; k < NUM_CH; k++) m_duty[k] = m_cur[k];
        m_upd = 1;
      end
    end
  endtask

  function automatic bit model_busy();
    bit b = 0;
    for (int k = 0; k < NUM_CH; k++)
      if (m_cur[k] != m_tgt[k] || m_jump[k]) b = 1;
    return b;
  endfunction

  // ---------------- checking helpers -------------------------------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int field(input int k);
    return int'(duty_flat[k*DUTY_W +: DUTY_W]);
  endfunction

  task automatic compare_model();
    logic [NUM_CH*DUTY_W-1:0] exp_flat;
    exp_flat = '0;
    for (int k = 0; k < NUM_CH; k++) exp_flat[k*DUTY_W +: DUTY_W] = DUTY_W'(m_duty[k]);
    check("model_ready", cmd_ready, (m_win == 0));
    check("model_upd", upd, m_upd);
    check("model_duty", duty_flat, exp_flat);
    if (m_win == 0) check("model_busy", busy, model_busy());
  endtask

  // One clock: drive inputs, advance model, sample 1 time unit after the edge.
  task automatic cycle(input bit ps, input bit v, input int ch, input int d, input bit rp);
    period_start = ps; cmd_valid = v; cmd_ch = 3'(ch); cmd_duty = DUTY_W'(d); cmd_ramp = rp;
    if (reset) model_reset();
    else model_edge(ps, v, ch, d, rp);
    @(posedge clk);
    #1;
    compare_model();
    period_start = 0; cmd_valid = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1;
    model_reset();
    idle(2);
    reset = 0;
  endtask

  // ---------------- directed vector table --------------------------------
  typedef struct {
    int n; bit rst; bit ps; bit v; int ch; int duty; bit rp;
    bit e_rdy; bit e_upd; bit e_busy; int f_ch; int f_val;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int n, input bit rst, input bit ps, input bit v, input int ch,
                     input int duty, input bit rp, input bit e_rdy, input bit e_upd,
                     input bit e_busy, input int f_ch, input int f_val);
    vec_t t;
    t.n = n; t.rst = rst; t.ps = ps; t.v = v; t.ch = ch; t.duty = duty; t.rp = rp;
    t.e_rdy = e_rdy; t.e_upd = e_upd; t.e_busy = e_busy; t.f_ch = f_ch; t.f_val = f_val;
    tbl.push_back(t);
  endtask

  initial begin
    int since;
    bit ps, v, rp;
    int ch, d;
    logic [NUM_CH*DUTY_W-1:0] zero_flat;
    zero_flat = '0;

    //  n  rst ps v  ch duty rp   rdy upd busy fch fval
    // jump: ch3 <- 40 at the next boundary
    add(2, 1, 0, 0, 0, 0,   0,   1, 0, 0,   3, 0);
    add(1, 0, 0, 1, 3, 40,  0,   1, 0, 1,   3, 0);
    add(1, 0, 1, 0, 0, 0,   0,   0, 0, 1,   3, 0);
    add(8, 0, 0, 0, 0, 0,   0,   0, 0, 0,   3, 0);
    add(1, 0, 0, 0, 0, 0,   0,   1, 1, 0,   3, 40);
    add(1, 0, 0, 0, 0, 0,   0,   1, 0, 0,   2, 0);
    // clamp 127 -> 100, then ramp down to 98 (ticks on boundaries 4 and 8)
    add(1, 1, 0, 0, 0, 0,   0,   1, 0, 0,   7, 0);
    add(1, 0, 0, 1, 7, 127, 0,   1, 0, 1,   7, 0);
    add(1, 0, 1, 0, 0, 0,   0,   0, 0, 1,   7, 0);
    add(9, 0, 0, 0, 0, 0,   0,   1, 1, 0,   7, 100);
    add(1, 0, 0, 1, 7, 98,  1,   1, 0, 1,   7, 100);
    add(1, 0, 1, 0, 0, 0,   0,   0, 0, 1,   7, 100);
    add(9, 0, 0, 0, 0, 0,   0,   1, 1, 1,   7, 100);
    add(1, 0, 1, 0, 0, 0,   0,   0, 0, 1,   7, 100);
    add(9, 0, 0, 0, 0, 0,   0,   1, 1, 1,   7, 100);
    add(1, 0, 1, 0, 0, 0,   0,   0, 0, 1,   7, 100);
    add(9, 0, 0, 0, 0, 0,   0,   1, 1, 1,   7, 99);
    add(1, 0, 1, 0, 0, 0,   0,   0, 0, 1,   7, 99);
    add(9, 0, 0, 0, 0, 0,   0,   1, 1, 1,   7, 99);
    add(1, 0, 1, 0, 0, 0,   0,   0, 0, 1,   7, 99);
    add(9, 0, 0, 0, 0, 0,   0,   1, 1, 1,   7, 99);
    add(1, 0, 1, 0, 0, 0,   0,   0, 0, 1,   7, 99);
    add(9, 0, 0, 0, 0, 0,   0,   1, 1, 1,   7, 99);
    add(1, 0, 1, 0, 0, 0,   0,   0, 0, 1,   7, 99);
    add(9, 0, 0, 0, 0, 0,   0,   1, 1, 0,   7, 98);
    // handshake held through the sweep, collision, last-command-wins
    add(1, 1, 0, 0, 0, 0,   0,   1, 0, 0,   1, 0);
    add(1, 0, 1, 0, 0, 0,   0,   0, 0, 0,   1, 0);
    add(9, 0, 0, 1, 1, 20,  0,   1, 1, 0,   1, 0);
    add(1, 0, 0, 1, 1, 20,  0,   1, 0, 1,   1, 0);
    add(1, 0, 1, 0, 0, 0,   0,   0, 0, 1,   1, 0);
    add(9, 0, 0, 0, 0, 0,   0,   1, 1, 0,   1, 20);
    add(1, 0, 1, 1, 5, 77,  0,   0, 0, 1,   5, 0);
    add(9, 0, 0, 0, 0, 0,   0,   1, 1, 0,   5, 77);
    add(1, 0, 0, 1, 6, 50,  1,   1, 0, 1,   6, 0);
    add(1, 0, 0, 1, 6, 33,  0,   1, 0, 1,   6, 0);
    add(1, 0, 1, 0, 0, 0,   0,   0, 0, 1,   6, 0);
    add(9, 0, 0, 0, 0, 0,   0,   1, 1, 0,   6, 33);

    foreach (tbl[i]) begin
      if (tbl[i].rst) begin
        reset = 1;
        model_reset();
      end
      for (int c = 0; c < tbl[i].n; c++)
        cycle(tbl[i].ps, tbl[i].v, tbl[i].ch, tbl[i].duty, tbl[i].rp);
      if (tbl[i].rst) reset = 0;
      check($sformatf("vec%0d_ready", i), cmd_ready, tbl[i].e_rdy);
      check($sformatf("vec%0d_upd", i), upd, tbl[i].e_upd);
      check($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
      check($sformatf("vec%0d_ch%0d", i, tbl[i].f_ch), field(tbl[i].f_ch), tbl[i].f_val);
      $display("vec %0d n=%0d rst=%0b ps=%0b valid=%0b ch=%0d duty=%0d ramp=%0b -> ready=%0b upd=%0b busy=%0b ch%0d=%0d",
               i, tbl[i].n, tbl[i].rst, tbl[i].ps, tbl[i].v, tbl[i].ch, tbl[i].duty, tbl[i].rp,
               cmd_ready, upd, busy, tbl[i].f_ch, field(tbl[i].f_ch));
    end

    // ramp up ch0 0 -> 5 with a 100-cycle PWM period; one step per 4 boundaries
    do_reset();
    cycle(0, 1, 0, 5, 1);
    for (int k = 1; k <= 20; k++) begin
      cycle(1, 0, 0, 0, 0);
      idle(SWEEP_LEN);
      check($sformatf("ramp_upd_b%0d", k), upd, 1);
      check($sformatf("ramp_ch0_b%0d", k), field(0), k / STEP_DIV);
      check($sformatf("ramp_busy_b%0d", k), busy, (k < 20));
      $display("ramp boundary=%0d ch0=%0d busy=%0b", k, field(0), busy);
      idle(100 - 1 - SWEEP_LEN);
    end

    // reset in the middle of a sweep
    do_reset();
    cycle(0, 1, 2, 60, 0);
    cycle(1, 0, 0, 0, 0);
    idle(SWEEP_LEN);
    check("rst_pre_ch2", field(2), 60);
    cycle(1, 0, 0, 0, 0);
    idle(3);
    reset = 1;
    model_reset();
    #1;
    check("rst_async_duty", duty_flat, zero_flat);
    check("rst_async_upd", upd, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_ready", cmd_ready, 1);
    idle(2);
    reset = 0;
    idle(12);
    check("rst_after_duty", duty_flat, zero_flat);
    cycle(1, 0, 0, 0, 0);
    idle(SWEEP_LEN);
    check("rst_next_upd", upd, 1);
    check("rst_next_duty", duty_flat, zero_flat);
    $display("reset-mid-sweep done duty=%0h upd=%0b", duty_flat, upd);

    // random traffic against the model
    do_reset();
    since = 100;
    for (int i = 0; i < 1500; i++) begin
      ps = (since >= SWEEP_LEN + 1) && ($urandom_range(0, 3) == 0);
      v  = ($urandom_range(0, 3) == 0);
      ch = int'($urandom_range(0, NUM_CH - 1));
      d  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(95, 127)) : int'($urandom_range(0, 127));
      rp = ($urandom_range(0, 1) == 1);
      since = ps ? 1 : since + 1;
      cycle(ps, v, ch, d, rp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
